// File: rtl/pal_scan_ctrl_pkg.sv
// Shared types and helpers for the serial 3-bit palindrome window scanner.
package pal_ctrl_pkg;

    localparam int WORD_W_DEF = 8;
    localparam int CNT_W_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Reverses the low w bits of v; bits above w come back as zero.
    function automatic logic [63:0] bitrev(input logic [63:0] v, input int unsigned w);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) begin
            r[i] = v[63-i];
        end
        return r >> (64 - w);
    endfunction

endpackage

// File: rtl/pal_scan_ctrl_if.sv
// Word-in / serial-out / result-out handshake bundle for pal_scan_ctrl.
interface pal_scan_ctrl_if
    import pal_ctrl_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic              word_valid_i;
    logic [WORD_W-1:0] word_i;
    logic              word_ready_o;
    logic              abort_i;
    logic              bit_valid_o;
    logic              bit_o;
    logic              hit_o;
    logic              res_valid_o;
    logic              res_ready_i;
    logic [CNT_W-1:0]  hit_count_o;
    logic              word_pal_o;

    modport master (
        output word_valid_i, word_i, abort_i, res_ready_i,
        input  word_ready_o, bit_valid_o, bit_o, hit_o, res_valid_o, hit_count_o, word_pal_o
    );

    modport slave (
        input  word_valid_i, word_i, abort_i, res_ready_i,
        output word_ready_o, bit_valid_o, bit_o, hit_o, res_valid_o, hit_count_o, word_pal_o
    );
endinterface

// File: rtl/pal_scan_ctrl_window.sv
// 3-bit window detector: flags a bit that equals the bit seen two valid bits earlier.
module pal3_window (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic bit_valid,
    input  logic serial_bit,
    output logic hit
);
    logic [1:0] hist;
    logic [1:0] fill;

    // NOTE: non-blocking for every register so each one samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            hist <= '0;
            fill <= '0;
        end else if (bit_valid) begin
            hist <= {hist[0], serial_bit};
            if (fill != 2'd2) fill <= fill + 2'd1;
        end
    end

    // A window only exists once two earlier bits are in the history.
    assign hit = bit_valid && (fill == 2'd2) && (serial_bit == hist[1]);
endmodule

// File: rtl/pal_scan_ctrl.sv
// Accepts a word, serializes it MSB-first, counts palindromic 3-bit windows, returns the result.
module pal_scan_ctrl
    import pal_ctrl_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           reset,
    pal_scan_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(WORD_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    state_t            state, state_next;
    logic              accept;
    logic [WORD_W-1:0] shreg;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  hit_count;
    logic              word_pal;
    logic              in_shift;
    logic              hit;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: defaults first so no path through the case leaves a latch.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.word_valid_i && !bus.abort_i) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.abort_i)          state_next = IDLE;
                else if (idx == LAST_IDX) state_next = DONE;
            end
            DONE: begin
                if (bus.abort_i || bus.res_ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg     <= '0;
            idx       <= '0;
            hit_count <= '0;
            word_pal  <= 1'b0;
        end else if (accept) begin
            shreg     <= bus.word_i;
            idx       <= '0;
            hit_count <= '0;
            word_pal  <= (64'(bus.word_i) == bitrev(64'(bus.word_i), WORD_W));
        end else if (state != IDLE && bus.abort_i) begin
            hit_count <= '0;
        end else if (in_shift) begin
            shreg <= shreg << 1;
            idx   <= idx + IDX_W'(1);
            if (hit && hit_count != '1) hit_count <= hit_count + CNT_W'(1);
        end
    end

    pal3_window u_window (
        .clk        (clk),
        .reset      (reset),
        .clear      (accept || bus.abort_i),
        .bit_valid  (in_shift),
        .serial_bit (bus.bit_o),
        .hit        (hit)
    );

    assign in_shift         = (state == SHIFT);
    assign bus.word_ready_o = (state == IDLE) && !reset;
    assign bus.bit_valid_o  = in_shift;
    assign bus.bit_o        = in_shift & shreg[WORD_W-1];
    assign bus.hit_o        = hit;
    assign bus.res_valid_o  = (state == DONE);
    assign bus.hit_count_o  = hit_count;
    assign bus.word_pal_o   = word_pal;
endmodule

// File: tb/tb_pal_scan_ctrl.sv
// Self-checking bench: word-level reference model, per-cycle compare, directed and random words.
module tb_pal_scan_ctrl;
    localparam int W  = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    pal_scan_ctrl_if #(.WORD_W(W), .CNT_W(CW)) bus ();

    pal_scan_ctrl #(.WORD_W(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // k-th serialized bit (k = 1..W), MSB first.
    function automatic logic ref_bit(input logic [W-1:0] w, input int k);
        if (k < 1 || k > W) return 1'b0;
        return w[W-k];
    endfunction

    function automatic int ref_hits(input logic [W-1:0] w);
        int n = 0;
        for (int k = 3; k <= W; k++) if (ref_bit(w, k) == ref_bit(w, k - 2)) n++;
        return n;
    endfunction

    function automatic logic ref_pal(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) if (w[i] != w[W-1-i]) return 1'b0;
        return 1'b1;
    endfunction

    // Model: m_pos = 0 idle, 1..W = emitting bit m_pos, W+1 = result pending.
    int         m_pos      = 0;
    logic [W-1:0] m_word   = '0;
    bit         m_started  = 0;
    bit         m_cnt_zero = 0;
    bit         m_pal_zero = 0;
    int         m_accepts  = 0;
    int         m_results  = 0;

    always @(posedge clk) begin
        m_started = 1;
        if (reset) begin
            m_pos      = 0;
            m_cnt_zero = 1;
            m_pal_zero = 1;
        end else if (m_pos == 0) begin
            if (bus.word_valid_i && !bus.abort_i) begin
                m_word     = bus.word_i;
                m_pos      = 1;
                m_cnt_zero = 0;
                m_pal_zero = 0;
                m_accepts++;
            end
        end else if (bus.abort_i) begin
            m_pos      = 0;
            m_cnt_zero = 1;
        end else if (m_pos <= W) begin
            m_pos++;
        end else if (bus.res_ready_i) begin
            m_pos = 0;
            m_results++;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            check("word_ready", bus.word_ready_o, (m_pos == 0) && !reset);
            check("bit_valid", bus.bit_valid_o, (m_pos >= 1) && (m_pos <= W));
            check("bit", bus.bit_o, ref_bit(m_word, m_pos));
            check("hit", bus.hit_o, (m_pos >= 3) && (m_pos <= W) &&
                  (ref_bit(m_word, m_pos) == ref_bit(m_word, m_pos - 2)));
            check("res_valid", bus.res_valid_o, m_pos == W + 1);
            if (m_pos == W + 1) begin
                check("hit_count", bus.hit_count_o, ref_hits(m_word));
                check("word_pal", bus.word_pal_o, ref_pal(m_word));
            end
            if (m_cnt_zero) check("hit_count_cleared", bus.hit_count_o, 0);
            if (m_pal_zero) check("word_pal_cleared", bus.word_pal_o, 0);
        end
    end

    always @(negedge clk) begin
        if (m_started && bus.res_valid_o)
            assert (int'(bus.hit_count_o) <= W - 2)
            else $error("FAIL hit_count_range: got %0d", bus.hit_count_o);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed scan from IDLE with literal bit/hit/result expectations.
    task automatic scan_word(input logic [W-1:0] w, input logic [W-1:0] hit_pat,
                             input int exp_cnt, input logic exp_pal);
        bus.word_valid_i = 1'b1;
        bus.word_i       = w;
        @(negedge clk);
        check("dir_ready", bus.word_ready_o, 1);
        tick();
        bus.word_valid_i = 1'b0;
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            check("dir_bit", bus.bit_o, w[W-k]);
            check("dir_hit", bus.hit_o, hit_pat[W-k]);
            tick();
        end
        @(negedge clk);
        check("dir_res_valid", bus.res_valid_o, 1);
        check("dir_hit_count", bus.hit_count_o, exp_cnt);
        check("dir_word_pal", bus.word_pal_o, exp_pal);
        bus.res_ready_i = 1'b1;
        tick();
        bus.res_ready_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc_cyc[$];
        int target;
        int budget;
        logic [W-1:0] w;

        reset            = 1'b1;
        bus.word_valid_i = 1'b1;
        bus.word_i       = 8'h3C;
        bus.abort_i      = 1'b0;
        bus.res_ready_i  = 1'b0;

        // Reset held for two edges with a word on offer.
        tick();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_ready", bus.word_ready_o, 0);
            check("rst_bit_valid", bus.bit_valid_o, 0);
            check("rst_res_valid", bus.res_valid_o, 0);
            check("rst_hit_count", bus.hit_count_o, 0);
            check("rst_word_pal", bus.word_pal_o, 0);
            if (i == 0) tick();
        end
        tick();
        reset            = 1'b0;
        bus.word_valid_i = 1'b0;
        @(negedge clk);
        check("post_rst_ready", bus.word_ready_o, 1);
        check("post_rst_no_accept", bus.bit_valid_o, 0);
        tick();

        scan_word(8'b1010_1010, 8'b0011_1111, 6, 1'b0);
        scan_word(8'b1100_0011, 8'b0000_1100, 2, 1'b1);

        // Backpressure in DONE with another word waiting.
        bus.word_valid_i = 1'b1;
        bus.word_i       = 8'h5A;
        tick();
        bus.word_i = 8'h96;
        repeat (W) tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_res_valid", bus.res_valid_o, 1);
            check("bp_ready", bus.word_ready_o, 0);
            check("bp_hit_count", bus.hit_count_o, 4);
            check("bp_word_pal", bus.word_pal_o, 1);
            tick();
        end
        bus.res_ready_i = 1'b1;
        tick();
        bus.res_ready_i = 1'b0;
        @(negedge clk);
        check("bp_release_ready", bus.word_ready_o, 1);
        tick();
        bus.word_valid_i = 1'b0;
        @(negedge clk);
        check("bp_next_bit_valid", bus.bit_valid_o, 1);
        check("bp_next_bit", bus.bit_o, 1);
        repeat (W) tick();
        bus.res_ready_i = 1'b1;
        tick();
        bus.res_ready_i = 1'b0;

        // Abort on bit index 4.
        bus.word_valid_i = 1'b1;
        bus.word_i       = 8'hE7;
        tick();
        bus.word_valid_i = 1'b0;
        repeat (4) tick();
        bus.abort_i = 1'b1;
        @(negedge clk);
        check("abort_in_shift", bus.bit_valid_o, 1);
        tick();
        bus.abort_i = 1'b0;
        @(negedge clk);
        check("abort_bit_valid", bus.bit_valid_o, 0);
        check("abort_res_valid", bus.res_valid_o, 0);
        check("abort_hit_count", bus.hit_count_o, 0);
        check("abort_ready", bus.word_ready_o, 1);
        tick();
        scan_word(8'b1000_0001, 8'b0001_1110, 4, 1'b1);

        // Back-to-back acceptance period.
        bus.word_valid_i = 1'b1;
        bus.res_ready_i  = 1'b1;
        for (int i = 0; i < 3 * (W + 2); i++) begin
            bus.word_i = W'($urandom);
            @(negedge clk);
            if (bus.word_ready_o && bus.word_valid_i) acc_cyc.push_back(cyc);
            tick();
        end
        check("b2b_accepts", acc_cyc.size() >= 2, 1);
        for (int i = 1; i < acc_cyc.size(); i++)
            check("b2b_period", acc_cyc[i] - acc_cyc[i-1], W + 2);

        // Random words with random backpressure and occasional aborts.
        target = m_accepts + 200;
        budget = 20000;
        while (m_accepts < target && budget > 0) begin
            w = W'($urandom);
            if ($urandom_range(0, 3) == 0)
                for (int i = 0; i < W / 2; i++) w[i] = w[W-1-i];
            bus.word_i       = w;
            bus.word_valid_i = ($urandom_range(0, 3) != 0);
            bus.res_ready_i  = ($urandom_range(0, 2) != 0);
            bus.abort_i      = ($urandom_range(0, 31) == 0);
            tick();
            budget--;
        end
        check("random_budget", m_accepts >= target, 1);
        check("random_results_seen", m_results > 100, 1);

        // Drain, then reset in the middle of a scan.
        bus.word_valid_i = 1'b0;
        bus.abort_i      = 1'b0;
        bus.res_ready_i  = 1'b1;
        budget = 50;
        while (m_pos != 0 && budget > 0) begin
            tick();
            budget--;
        end
        check("drain_budget", m_pos == 0, 1);
        bus.word_valid_i = 1'b1;
        bus.word_i       = 8'hA5;
        tick();
        bus.word_valid_i = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("midreset_bit_valid", bus.bit_valid_o, 0);
        check("midreset_hit_count", bus.hit_count_o, 0);
        repeat (W + 3) begin
            @(negedge clk);
            check("midreset_no_result", bus.res_valid_o, 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
